// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline boundary bundle: EX-side handshake/payload, MEM-side head entry, forwarding taps.
// The register block uses the slave modport; the EX/MEM side uses master.
interface ex_mem_reg_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [31:0]     ex_inst;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifter_res;
    logic [1:0]      res_sel;
    logic            ex_word;
    logic [4:0]      ex_rd_addr;
    logic            ex_rd_wen;
    logic            ex_mem_ren;
    logic            ex_mem_wen;
    logic [1:0]      ex_mem_size;
    logic            ex_mem_unsigned;
    logic [XLEN-1:0] ex_store_data;

    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_pc;
    logic [31:0]     mem_inst;
    logic [XLEN-1:0] mem_res;
    logic [4:0]      mem_rd_addr;
    logic            mem_rd_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] mem_store_data;

    logic            fwd_valid;
    logic [4:0]      fwd_rd_addr;
    logic [XLEN-1:0] fwd_data;

    modport slave (
        input  flush, ex_valid, ex_pc, ex_inst, alu_res, shifter_res, res_sel, ex_word,
               ex_rd_addr, ex_rd_wen, ex_mem_ren, ex_mem_wen, ex_mem_size, ex_mem_unsigned,
               ex_store_data, mem_ready,
        output ex_ready, mem_valid, mem_pc, mem_inst, mem_res, mem_rd_addr, mem_rd_wen,
               mem_ren, mem_wen, mem_size, mem_unsigned, mem_store_data,
               fwd_valid, fwd_rd_addr, fwd_data
    );

    modport master (
        output flush, ex_valid, ex_pc, ex_inst, alu_res, shifter_res, res_sel, ex_word,
               ex_rd_addr, ex_rd_wen, ex_mem_ren, ex_mem_wen, ex_mem_size, ex_mem_unsigned,
               ex_store_data, mem_ready,
        input  ex_ready, mem_valid, mem_pc, mem_inst, mem_res, mem_rd_addr, mem_rd_wen,
               mem_ren, mem_wen, mem_size, mem_unsigned, mem_store_data,
               fwd_valid, fwd_rd_addr, fwd_data
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: result select, RV64 word sign-extension, valid/ready both sides, flush.
// Define EX_MEM_SKID_EN for a two-entry head+skid build with a registered ex_ready.
module ex_mem_reg #(
    parameter int         XLEN      = 64,
    parameter logic [1:0] RES_ALU   = 2'b00,
    parameter logic [1:0] RES_SHIFT = 2'b01,
    parameter logic [1:0] RES_LINK  = 2'b10
) (
    input logic         clk,
    input logic         rst,
    ex_mem_reg_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] res;
        logic [4:0]      rd_addr;
        logic            rd_wen;
        logic            ren;
        logic            wen;
        logic [1:0]      size;
        logic            unsgn;
        logic [XLEN-1:0] store_data;
    } entry_t;

    entry_t          incoming;
    entry_t          head;
    logic [XLEN-1:0] sel_res;
    logic            head_valid;
    logic            accept;
    logic            depart;

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves sel_res holding (no latch).
        sel_res = '0;
        case (bus.res_sel)
            RES_ALU:   sel_res = bus.alu_res;
            RES_SHIFT: sel_res = bus.shifter_res;
            RES_LINK:  sel_res = bus.ex_pc + XLEN'(4);
            default:   sel_res = '0;
        endcase
    end

    // W-type ops rely on this extension for every source, shifter included.
    assign incoming = '{
        pc:         bus.ex_pc,
        inst:       bus.ex_inst,
        res:        bus.ex_word ? {{(XLEN-32){sel_res[31]}}, sel_res[31:0]} : sel_res,
        rd_addr:    bus.ex_rd_addr,
        rd_wen:     bus.ex_rd_wen & (bus.ex_rd_addr != 5'd0),
        ren:        bus.ex_mem_ren,
        wen:        bus.ex_mem_wen,
        size:       bus.ex_mem_size,
        unsgn:      bus.ex_mem_unsigned,
        store_data: bus.ex_store_data
    };

    assign accept = bus.ex_valid & bus.ex_ready;
    assign depart = head_valid & bus.mem_ready;

`ifdef EX_MEM_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    entry_t skid;
    logic   ready_q;

    assign head_valid   = (state != EMPTY);
    assign bus.ex_ready = ready_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            head    <= '0;
        end else if (bus.flush) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    head  <= incoming;
                    state <= ONE;
                end
                ONE: begin
                    if (accept && depart) begin
                        head <= incoming;
                    end else if (depart) begin
                        state <= EMPTY;
                    end else if (accept) begin
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end
                end
                TWO: if (depart) begin
                    head    <= skid;
                    state   <= ONE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: skid payload has no reset; it is only ever observed through the head after a valid fill.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && state == ONE && accept && !depart) begin
            skid <= incoming;
        end
    end
`else
    logic valid_q;

    assign head_valid   = valid_q;
    assign bus.ex_ready = ~valid_q | bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            head    <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            head    <= incoming;
            valid_q <= 1'b1;
        end else if (depart) begin
            valid_q <= 1'b0;
        end
    end
`endif

    assign bus.mem_valid      = head_valid;
    assign bus.mem_pc         = head.pc;
    assign bus.mem_inst       = head.inst;
    assign bus.mem_res        = head.res;
    assign bus.mem_rd_addr    = head.rd_addr;
    assign bus.mem_rd_wen     = head.rd_wen;
    assign bus.mem_ren        = head.ren;
    assign bus.mem_wen        = head.wen;
    assign bus.mem_size       = head.size;
    assign bus.mem_unsigned   = head.unsgn;
    assign bus.mem_store_data = head.store_data;

    // Loads are excluded: their final value is not known until MEM.
    assign bus.fwd_valid   = head_valid & head.rd_wen & ~head.ren;
    assign bus.fwd_rd_addr = head.rd_addr;
    assign bus.fwd_data    = head.res;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; expectations follow EX_MEM_SKID_EN where the builds differ.
module tb_ex_mem_reg;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ex_mem_reg_if #(.XLEN(XLEN)) bus ();

    ex_mem_reg #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] pc, input logic [1:0] sel, input logic [63:0] alu,
                           input logic [63:0] sh, input logic word, input logic [4:0] rd,
                           input logic rd_wen, input logic ren);
        logic [63:0] pcv;
        pcv = pc;
        bus.ex_valid        = 1'b1;
        bus.ex_pc           = pcv;
        bus.ex_inst         = pcv[31:0] | 32'h0000_0013;
        bus.res_sel         = sel;
        bus.alu_res         = alu;
        bus.shifter_res     = sh;
        bus.ex_word         = word;
        bus.ex_rd_addr      = rd;
        bus.ex_rd_wen       = rd_wen;
        bus.ex_mem_ren      = ren;
        bus.ex_mem_wen      = 1'b0;
        bus.ex_mem_size     = 2'd3;
        bus.ex_mem_unsigned = 1'b0;
        bus.ex_store_data   = pcv ^ 64'hA5A5_A5A5_A5A5_A5A5;
    endtask

    task automatic present_alu(input logic [63:0] pc);
        present(pc, 2'b00, pc + 64'd1, 64'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        logic [234:0] d;
        bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.mem_ready = 1'b0;
        present_alu(64'h0);
        bus.ex_valid = 1'b0;
        rst = 1'b1;
        step(); step();
        d = {bus.mem_pc, bus.mem_inst, bus.mem_res, bus.mem_rd_addr, bus.mem_rd_wen, bus.mem_ren,
             bus.mem_wen, bus.mem_size, bus.mem_unsigned, bus.mem_store_data};
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b want 0", bus.fwd_valid); end
        checks++; if (d !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", d); end
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b want 1", bus.ex_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_shift();
        bus.mem_ready = 1'b1;
        present(64'h100, 2'b01, 64'hDEAD, 64'h0000_0000_8000_0000, 1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL ws_ex_ready: got %b want 1", bus.ex_ready); end
        step();
        bus.ex_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL ws_mem_valid: got %b want 1", bus.mem_valid); end
        checks++; if (bus.mem_res !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ws_mem_res: got %h want ffffffff80000000", bus.mem_res); end
        checks++; if (bus.mem_pc !== 64'h100) begin errors++; $display("FAIL ws_mem_pc: got %h want 100", bus.mem_pc); end
        checks++; if (bus.mem_store_data !== 64'hA5A5_A5A5_A5A5_A4A5) begin errors++; $display("FAIL ws_store_data: got %h want a5a5a5a5a5a5a4a5", bus.mem_store_data); end
        checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_rd_addr !== 5'd5 || bus.fwd_data !== 64'hFFFF_FFFF_8000_0000)
            begin errors++; $display("FAIL ws_fwd: got v=%b rd=%0d d=%h want v=1 rd=5 d=ffffffff80000000", bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data); end
        step();
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL ws_depart: got %b want 0", bus.mem_valid); end
    endtask

    task automatic test_result_select();
        logic [1:0]  sel  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [63:0] alu  [6] = '{64'h0000_0001_8000_0000, 64'h1234_5678_7FFF_FFFF, 64'h1, 64'h2, 64'h3, 64'h42};
        logic [63:0] sh   [6] = '{64'h9, 64'h9, 64'hFFFF_0000_0000_0001, 64'h9, 64'h9, 64'h9};
        logic [63:0] pc   [6] = '{64'h10, 64'h14, 64'h18, 64'h0000_0001_7FFF_FFFC, 64'h20, 64'h24};
        logic        word [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ren  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] eres [6] = '{64'h0000_0001_8000_0000, 64'h0000_0000_7FFF_FFFF, 64'hFFFF_0000_0000_0001,
                                  64'hFFFF_FFFF_8000_0000, 64'h0, 64'h42};
        logic        efwd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            present(pc[i], sel[i], alu[i], sh[i], word[i], 5'd9, 1'b1, ren[i]);
            step();
            checks++; if (bus.mem_res !== eres[i]) begin errors++; $display("FAIL rs_res[%0d]: got %h want %h", i, bus.mem_res, eres[i]); end
            checks++; if (bus.fwd_valid !== efwd[i]) begin errors++; $display("FAIL rs_fwd[%0d]: got %b want %b", i, bus.fwd_valid, efwd[i]); end
        end
        bus.ex_valid = 1'b0;
        step();
    endtask

    task automatic test_link_x0();
        bus.mem_ready = 1'b0;
        present(64'h8000_0000, 2'b10, 64'h7, 64'h7, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        bus.ex_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL lx_mem_valid: got %b want 1", bus.mem_valid); end
        checks++; if (bus.mem_res !== 64'h8000_0004) begin errors++; $display("FAIL lx_mem_res: got %h want 80000004", bus.mem_res); end
        checks++; if (bus.mem_rd_wen !== 1'b0) begin errors++; $display("FAIL lx_rd_wen: got %b want 0", bus.mem_rd_wen); end
        checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL lx_fwd_valid: got %b want 0", bus.fwd_valid); end
        bus.mem_ready = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        logic [63:0] pcs [3] = '{64'h2000, 64'h2004, 64'h2008};
`ifdef EX_MEM_SKID_EN
        logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          exp_acc [3] = '{0, 1, 4};
`else
        logic        exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          exp_acc [3] = '{0, 3, 4};
`endif
        int          exp_dep [3] = '{3, 4, 5};
        logic [63:0] dep_pc [$];
        int          dep_cyc [$];
        int          acc_cyc [$];
        int          idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.mem_ready = (cyc >= 3);
            if (idx < 3) present_alu(pcs[idx]); else bus.ex_valid = 1'b0;
            #1;
            if (cyc < 6) begin
                checks++; if (bus.ex_ready !== exp_rdy[cyc]) begin errors++; $display("FAIL bp_ex_ready[c%0d]: got %b want %b", cyc, bus.ex_ready, exp_rdy[cyc]); end
            end
            if (bus.mem_valid && bus.mem_ready) begin dep_pc.push_back(bus.mem_pc); dep_cyc.push_back(cyc); end
            if (bus.ex_valid && bus.ex_ready) begin acc_cyc.push_back(cyc); idx++; end
            step();
        end
        bus.ex_valid = 1'b0;
        checks++; if (dep_pc.size() != 3 || acc_cyc.size() != 3) begin
            errors++; $display("FAIL bp_count: got dep=%0d acc=%0d want 3/3", dep_pc.size(), acc_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (dep_pc[i] !== pcs[i] || dep_cyc[i] != exp_dep[i])
                    begin errors++; $display("FAIL bp_depart[%0d]: got pc=%h c%0d want pc=%h c%0d", i, dep_pc[i], dep_cyc[i], pcs[i], exp_dep[i]); end
                checks++; if (acc_cyc[i] != exp_acc[i])
                    begin errors++; $display("FAIL bp_accept[%0d]: got c%0d want c%0d", i, acc_cyc[i], exp_acc[i]); end
            end
        end
    endtask

    task automatic test_flush();
        bus.mem_ready = 1'b0;
        present_alu(64'h3000); step();
        present_alu(64'h3004); step();
        present_alu(64'h30F0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL fl_ex_ready_during: got %b want 0", bus.ex_ready); end
        step();
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fl_mem_valid: got %b want 0", bus.mem_valid); end
        checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL fl_fwd_valid: got %b want 0", bus.fwd_valid); end
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL fl_ex_ready_after: got %b want 1", bus.ex_ready); end
        checks++; if (bus.mem_pc !== 64'h3000) begin errors++; $display("FAIL fl_data_kept: got %h want 3000", bus.mem_pc); end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fl_ghost[%0d]: got valid=%b pc=%h want valid=0", i, bus.mem_valid, bus.mem_pc); end
            step();
        end
    endtask

    task automatic test_streaming();
        int deps = 0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) present_alu(64'h4000 + 64'(4 * i)); else bus.ex_valid = 1'b0;
            #1;
            if (i < 8) begin
                checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL st_ex_ready[%0d]: got %b want 1", i, bus.ex_ready); end
            end
            if (i >= 1) begin
                checks++; if (bus.mem_valid !== 1'b1 || bus.mem_pc !== 64'h4000 + 64'(4 * (i - 1)))
                    begin errors++; $display("FAIL st_head[%0d]: got v=%b pc=%h want v=1 pc=%h", i, bus.mem_valid, bus.mem_pc, 64'h4000 + 64'(4 * (i - 1))); end
            end
            if (bus.mem_valid && bus.mem_ready) deps++;
            step();
        end
        checks++; if (deps != 8 || bus.mem_valid !== 1'b0) begin errors++; $display("FAIL st_departures: got %0d valid=%b want 8 valid=0", deps, bus.mem_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [234:0] d;
        bus.mem_ready = 1'b0;
        present_alu(64'h5000); step();
        present_alu(64'h5004); step();
        rst = 1'b1;
        step();
        d = {bus.mem_pc, bus.mem_inst, bus.mem_res, bus.mem_rd_addr, bus.mem_rd_wen, bus.mem_ren,
             bus.mem_wen, bus.mem_size, bus.mem_unsigned, bus.mem_store_data};
        checks++; if (bus.mem_valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b/%b want 0/0", bus.mem_valid, bus.fwd_valid); end
        checks++; if (d !== '0) begin errors++; $display("FAIL rm_data: got %h want 0", d); end
        rst = 1'b0;
        present_alu(64'h5008);
        #1;
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL rm_ex_ready: got %b want 1", bus.ex_ready); end
        step();
        bus.ex_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_pc !== 64'h5008) begin errors++; $display("FAIL rm_new: got v=%b pc=%h want v=1 pc=5008", bus.mem_valid, bus.mem_pc); end
        bus.mem_ready = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_word_shift();
        test_result_select();
        test_link_x0();
        test_backpressure();
        test_flush();
        test_streaming();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
